// File: rtl/fpu_normalise_ctrl_if.sv
// Handshake and data bundle between the FPU datapath, the
// normalise sequencer and the IEEE-754 pack stage.
interface fpu_normalise_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  z_e_in;
    logic [26:0] z_m_in;
    logic        guard_in;
    logic        round_in;
    logic        sticky_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_e;
    logic [23:0] out_m;
    logic        out_ovf;
    logic        out_denorm;
    logic        busy;

    modport master (
        output in_valid, z_e_in, z_m_in,
        output guard_in, round_in, sticky_in,
        output out_ready,
        input  in_ready, out_valid, out_e, out_m,
        input  out_ovf, out_denorm, busy
    );

    modport slave (
        input  in_valid, z_e_in, z_m_in,
        input  guard_in, round_in, sticky_in,
        input  out_ready,
        output in_ready, out_valid, out_e, out_m,
        output out_ovf, out_denorm, busy
    );
endinterface

// File: rtl/fpu_normalise_ctrl.sv
// Bit-serial normalise/round sequencer: right pre-shift, left
// normalise, subnormal right shift, then round-to-nearest-even.
module fpu_normalise_ctrl #(
    parameter int EMIN = -126,
    parameter int EMAX = 127
) (
    input logic clk,
    input logic rst,
    fpu_normalise_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        PRE,
        NORM_L,
        NORM_R,
        ROUND,
        DONE
    } state_t;

    localparam logic signed [9:0] E_MIN = 10'(EMIN);
    localparam logic signed [9:0] E_MAX = 10'(EMAX);

    state_t state;
    state_t state_nx;

    logic signed [9:0] e;
    logic [26:0]       m;
    logic              g;
    logic              r;
    logic              s;

    logic [9:0]  out_e_q;
    logic [23:0] out_m_q;
    logic        out_ovf_q;
    logic        out_denorm_q;

    logic              pre_sh;
    logic              nl_sh;
    logic              nr_sh;
    logic              rnd_up;
    logic [23:0]       rnd_m;
    logic signed [9:0] rnd_e;

    assign pre_sh = (m[26:24] != 3'b000);
    assign nl_sh  = !m[23] && (e > E_MIN);
    assign nr_sh  = (e < E_MIN);
    assign rnd_up = g && (r || s || m[0]);

    // All-ones mantissa carries out into the exponent.
    always_comb begin
        rnd_m = m[23:0];
        rnd_e = e;
        if (rnd_up) begin
            if (m[23:0] == 24'hFFFFFF) begin
                rnd_m = 24'h800000;
                rnd_e = e + 10'sd1;
            end else begin
                rnd_m = m[23:0] + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = PRE;
            PRE:     if (!pre_sh) state_nx = NORM_L;
            NORM_L:  if (!nl_sh) state_nx = NORM_R;
            NORM_R:  if (!nr_sh) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e            <= '0;
            m            <= '0;
            g            <= 1'b0;
            r            <= 1'b0;
            s            <= 1'b0;
            out_e_q      <= '0;
            out_m_q      <= '0;
            out_ovf_q    <= 1'b0;
            out_denorm_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    e <= bus.z_e_in;
                    m <= bus.z_m_in;
                    g <= bus.guard_in;
                    r <= bus.round_in;
                    s <= bus.sticky_in;
                end
                PRE, NORM_R: if ((state == PRE) ? pre_sh : nr_sh) begin
                    e <= e + 10'sd1;
                    s <= s | r;
                    r <= g;
                    g <= m[0];
                    m <= {1'b0, m[26:1]};
                end
                NORM_L: if (nl_sh) begin
                    e <= e - 10'sd1;
                    m <= {m[25:0], g};
                    g <= r;
                    r <= 1'b0;
                end
                ROUND: begin
                    out_e_q      <= rnd_e;
                    out_m_q      <= rnd_m;
                    out_ovf_q    <= (rnd_e > E_MAX);
                    out_denorm_q <= !rnd_m[23];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.out_e      = out_e_q;
    assign bus.out_m      = out_m_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_denorm = out_denorm_q;
endmodule

// File: tb/tb_fpu_normalise_ctrl.sv
// Directed vector bench for the normalise/round sequencer,
// with hand sequences for back-pressure and mid-op reset.
module tb_fpu_normalise_ctrl;
    typedef struct {
        logic [9:0]  e;
        logic [26:0] m;
        logic        g;
        logic        r;
        logic        s;
        logic [9:0]  xe;
        logic [23:0] xm;
        logic        xo;
        logic        xd;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_pass = 0;
    int n_tot  = 0;

    fpu_normalise_ctrl_if bus ();

    fpu_normalise_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        bus.z_e_in    = v.e;
        bus.z_m_in    = v.m;
        bus.guard_in  = v.g;
        bus.round_in  = v.r;
        bus.sticky_in = v.s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input vec_t v, input int lat);
        chk({tag, " lat"}, lat, v.lat);
        chk({tag, " out_e"}, {22'd0, bus.out_e}, {22'd0, v.xe});
        chk({tag, " out_m"}, {8'd0, bus.out_m}, {8'd0, v.xm});
        chk({tag, " ovf"}, {31'd0, bus.out_ovf}, {31'd0, v.xo});
        chk({tag, " den"}, {31'd0, bus.out_denorm}, {31'd0, v.xd});
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " idle ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, " idle valid"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    vec_t vecs[13];

    initial begin
        int lat;
        logic [23:0] held_m;
        logic [9:0]  held_e;

        vecs[0]  = '{10'd5,   27'h0800000, 0, 0, 0, 10'd5,   24'h800000, 0, 0, 4};
        vecs[1]  = '{10'd0,   27'h0000001, 0, 0, 0, 10'h3E9, 24'h800000, 0, 0, 27};
        vecs[2]  = '{10'd0,   27'h1000001, 0, 0, 0, 10'd1,   24'h800000, 0, 0, 5};
        vecs[3]  = '{10'd5,   27'h0800001, 1, 0, 0, 10'd5,   24'h800002, 0, 0, 4};
        vecs[4]  = '{10'd5,   27'h0800000, 1, 0, 0, 10'd5,   24'h800000, 0, 0, 4};
        vecs[5]  = '{10'd5,   27'h0FFFFFF, 1, 1, 0, 10'd6,   24'h800000, 0, 0, 4};
        vecs[6]  = '{10'd127, 27'h0FFFFFF, 1, 1, 0, 10'd128, 24'h800000, 1, 0, 4};
        vecs[7]  = '{10'h380, 27'h0800000, 0, 0, 0, 10'h382, 24'h200000, 0, 1, 6};
        vecs[8]  = '{10'd0,   27'h0000000, 0, 0, 0, 10'h382, 24'h000000, 0, 1, 130};
        vecs[9]  = '{10'd5,   27'h0800000, 1, 0, 1, 10'd5,   24'h800001, 0, 0, 4};
        vecs[10] = '{10'h381, 27'h0800003, 0, 0, 0, 10'h382, 24'h400002, 0, 1, 5};
        vecs[11] = '{10'h382, 27'h0400000, 0, 0, 0, 10'h382, 24'h400000, 0, 1, 4};
        vecs[12] = '{10'd2,   27'h4000000, 0, 0, 0, 10'd5,   24'h800000, 0, 0, 7};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.z_e_in    = '0;
        bus.z_m_in    = '0;
        bus.guard_in  = 1'b0;
        bus.round_in  = 1'b0;
        bus.sticky_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst out_m", {8'd0, bus.out_m}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            start(vecs[i]);
            chk($sformatf("v%0d busy", i), {31'd0, bus.busy}, 32'd1);
            wait_done(lat);
            check_out($sformatf("v%0d", i), vecs[i], lat);
            release_out($sformatf("v%0d", i));
        end

        // Back-pressure: DONE holds while new input is offered.
        start(vecs[3]);
        wait_done(lat);
        check_out("hold", vecs[3], lat);
        held_m = bus.out_m;
        held_e = bus.out_e;
        @(negedge clk);
        bus.z_e_in   = 10'd9;
        bus.z_m_in   = 27'h0000001;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold out_m", {8'd0, bus.out_m}, {8'd0, held_m});
            chk("hold out_e", {22'd0, bus.out_e}, {22'd0, held_e});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        release_out("hold");

        // Reset while the left normaliser is stepping.
        start(vecs[1]);
        repeat (5) @(posedge clk);
        #1;
        chk("mid busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid rst busy", {31'd0, bus.busy}, 32'd0);
        chk("mid rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid rst out_m", {8'd0, bus.out_m}, 32'd0);
        chk("mid rst out_e", {22'd0, bus.out_e}, 32'd0);
        chk("mid rst den", {31'd0, bus.out_denorm}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start(vecs[6]);
        wait_done(lat);
        check_out("post rst", vecs[6], lat);
        release_out("post rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
